// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - MDU issue/result bundle between Execute stage and multiply/divide unit
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             abortE;
  logic             mthiE;
  logic             mtloE;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output startE, opE, srcaE, srcbE, abortE, mthiE, mtloE,
    input  busy, done, hi, lo
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, abortE, mthiE, mtloE,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative radix-2 multiply/divide unit holding the HI/LO registers
module mdu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic  clk,
  input  logic  reset_n,
  mdu_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               dz;
  logic               neg_lo;
  logic               neg_hi;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               op_signed;
  logic               op_div;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     madd;
  logic [WIDTH:0]     dtrial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign op_signed = ~bus.opE[0];
  assign op_div    = bus.opE[1];
  assign a_neg     = op_signed & bus.srcaE[WIDTH-1];
  assign b_neg     = op_signed & bus.srcbE[WIDTH-1];
  assign b_zero    = (bus.srcbE == '0);
  assign a_abs     = a_neg ? -bus.srcaE : bus.srcaE;
  assign b_abs     = b_neg ? -bus.srcbE : bus.srcbE;

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
  assign madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign dtrial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign prod_fix = neg_lo ? -acc : acc;
  assign q_fix    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.startE) begin
            is_div <= op_div;
            dz     <= op_div & b_zero;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= op_div & a_neg;
            cnt    <= CNTW'(WIDTH);
            busy_q <= 1'b1;
            if (op_div) begin
              // divide-by-zero keeps the raw dividend so HI returns it unmodified
              acc   <= {{WIDTH{1'b0}}, (b_zero ? bus.srcaE : a_abs)};
              opnd  <= b_abs;
              state <= b_zero ? S_FIX : S_RUN;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b_abs};
              opnd  <= a_abs;
              state <= S_RUN;
            end
          end else begin
            if (bus.mthiE) hi_q <= bus.srcaE;
            if (bus.mtloE) lo_q <= bus.srcaE;
          end
        end
        S_RUN: begin
          if (bus.abortE) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            if (is_div) begin
              acc <= dtrial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
              acc <= {madd, acc[WIDTH-1:1]};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CNTW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          if (!bus.abortE) begin
            done_q <= 1'b1;
            if (!is_div) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (dz) begin
              hi_q <= acc[WIDTH-1:0];
              lo_q <= '1;
            end else begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu at WIDTH 32 and 8
module tb_mdu;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(32)) b32();
  mdu_if #(.WIDTH(8))  b8();

  mdu #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32.slave));
  mdu #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          w;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          eb;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic mh, input logic ml, input logic ab);
    if (w == 8) begin
      b8.startE = st; b8.opE = op; b8.srcaE = a[7:0]; b8.srcbE = b[7:0];
      b8.mthiE = mh; b8.mtloE = ml; b8.abortE = ab;
    end else begin
      b32.startE = st; b32.opE = op; b32.srcaE = a; b32.srcbE = b;
      b32.mthiE = mh; b32.mtloE = ml; b32.abortE = ab;
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? b8.busy : b32.busy;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? b8.done : b32.done;
  endfunction
  function automatic logic [31:0] get_hi(input int w);
    return (w == 8) ? {24'd0, b8.hi} : b32.hi;
  endfunction
  function automatic logic [31:0] get_lo(input int w);
    return (w == 8) ? {24'd0, b8.lo} : b32.lo;
  endfunction

  // Architectural result computed with 64-bit integer arithmetic
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
    longint unsigned mask, ua, ub;
    longint sa, sb, x, y, p, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua << (64 - w)) >>> (64 - w);
    sb = longint'(ub << (64 - w)) >>> (64 - w);
    x = op[0] ? longint'(ua) : sa;
    y = op[0] ? longint'(ub) : sb;
    if (!op[1]) begin
      p  = x * y;
      eh = 32'((longint'(longint'(unsigned'(p)) >> w)) & mask);
      el = 32'(p & mask);
    end else if (y == 0) begin
      eh = 32'(ua);
      el = 32'(mask);
    end else begin
      q  = x / y;
      r  = x % y;
      eh = 32'(r & mask);
      el = 32'(q & mask);
    end
  endfunction

  task automatic issue(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int poke, output logic [31:0] rh, output logic [31:0] rl,
                       output int bc, output int dc);
    @(negedge clk);
    drive(w, 1'b1, op, a, b, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(w, 1'b0, op, a, b, 1'b0, 1'b0, 1'b0);
    bc = 0; dc = 0; rh = '0; rl = '0;
    for (int i = 0; i < 80; i++) begin
      if (get_busy(w)) bc++;
      if (get_done(w)) begin
        dc++; rh = get_hi(w); rl = get_lo(w);
        break;
      end
      // Start/mthi/mtlo pulsed mid-operation must be ignored
      if (i == poke) drive(w, 1'b1, 2'b00, 32'h99, 32'h3, 1'b1, 1'b1, 1'b0);
      else           drive(w, 1'b0, op, a, b, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    drive(w, 1'b0, op, a, b, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    if (get_done(w)) dc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rh, rl, eh, el, ra, rb;
    logic [1:0]  rop;
    int bc, dc, w, cnt;

    tbl[0]  = '{32, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    tbl[1]  = '{32, 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    tbl[2]  = '{32, 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    tbl[3]  = '{32, 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    tbl[4]  = '{32, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    tbl[5]  = '{32, 2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    tbl[6]  = '{32, 2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
    tbl[7]  = '{8,  2'b01, 32'hFF,       32'hFF,       32'hFE,       32'h01,       9};
    tbl[8]  = '{8,  2'b10, 32'hF9,       32'h02,       32'hFF,       32'hFD,       9};
    tbl[9]  = '{8,  2'b10, 32'h80,       32'hFF,       32'h00,       32'h80,       9};
    tbl[10] = '{8,  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       9};
    tbl[11] = '{8,  2'b10, 32'hF9,       32'h00,       32'hF9,       32'hFF,       1};

    drive(32, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(8,  1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(b32.busy), 64'd0);
    check("reset_done", 64'(b32.done), 64'd0);
    check("reset_hi", 64'(b32.hi), 64'd0);
    check("reset_lo", 64'(b32.lo), 64'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      issue(tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, -1, rh, rl, bc, dc);
      check($sformatf("vec%0d_hi", i), 64'(rh), 64'(tbl[i].eh));
      check($sformatf("vec%0d_lo", i), 64'(rl), 64'(tbl[i].el));
      check($sformatf("vec%0d_busy", i), 64'(bc), 64'(tbl[i].eb));
      check($sformatf("vec%0d_done", i), 64'(dc), 64'd1);
    end

    for (int i = 0; i < 40; i++) begin
      w   = (i % 4 == 0) ? 8 : 32;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (w == 8) begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
      model(w, rop, ra, rb, eh, el);
      issue(w, rop, ra, rb, -1, rh, rl, bc, dc);
      check($sformatf("rnd%0d_hi", i), 64'(rh), 64'(eh));
      check($sformatf("rnd%0d_lo", i), 64'(rl), 64'(el));
      check($sformatf("rnd%0d_busy", i), 64'(bc), (rop[1] && rb == 0) ? 64'd1 : 64'(w + 1));
    end

    // Abort mid-run leaves HI/LO untouched and produces no done
    @(negedge clk); drive(32, 1'b0, 2'b00, 32'h11, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b00, 32'h22, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("mthi_pre", 64'(b32.hi), 64'h11);
    check("mtlo_pre", 64'(b32.lo), 64'h22);
    drive(32, 1'b1, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    drive(32, 1'b0, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(32, 1'b0, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    check("abort_busy", 64'(b32.busy), 64'd0);
    check("abort_hi", 64'(b32.hi), 64'h11);
    check("abort_lo", 64'(b32.lo), 64'h22);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (b32.done) cnt++; end
    check("abort_no_done", 64'(cnt), 64'd0);

    issue(32, 2'b11, 32'd100, 32'd7, 5, rh, rl, bc, dc);
    check("ignore_hi", 64'(rh), 64'd2);
    check("ignore_lo", 64'(rl), 64'd14);
    check("ignore_busy", 64'(bc), 64'd33);
    check("ignore_done", 64'(dc), 64'd1);

    // Asynchronous reset in the middle of a run
    drive(32, 1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 64'(b32.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 64'(b32.busy), 64'd0);
    check("async_done", 64'(b32.done), 64'd0);
    check("async_hi", 64'(b32.hi), 64'd0);
    check("async_lo", 64'(b32.lo), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    drive(32, 1'b0, 2'b00, 32'hA5A5A5A5, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b00, 32'h5A5A5A5A, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("mthi_a5", 64'(b32.hi), 64'hA5A5A5A5);
    check("mtlo_5a", 64'(b32.lo), 64'h5A5A5A5A);

    // Back-to-back: second start lands on the done cycle of the first
    drive(32, 1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    while (!b32.done && cnt < 80) begin @(negedge clk); cnt++; end
    check("b2b_first_done", 64'(b32.done), 64'd1);
    check("b2b_first_lo", 64'(b32.lo), 64'd12);
    drive(32, 1'b1, 2'b01, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(32, 1'b0, 2'b01, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    bc = 0; cnt = 0;
    while (!b32.done && cnt < 80) begin
      if (b32.busy) bc++;
      @(negedge clk); cnt++;
    end
    check("b2b_second_done", 64'(b32.done), 64'd1);
    check("b2b_second_busy", 64'(bc), 64'd33);
    check("b2b_second_lo", 64'(b32.lo), 64'd4);
    check("b2b_second_hi", 64'(b32.hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the pipelined MIPS core, parametrised in operand width. It executes MULT, MULTU, DIV and DIVU and holds the HI/LO architectural registers. It sits beside the ALU in the Execute stage. It is multi-cycle: it reports `busy` to the hazard unit, which stalls Decode on any MDU op, MFHI or MFLO while the unit is occupied.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4.
- `CNTW`, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `startE` in 1: start request, sampled only in IDLE.
- `opE` in 2: operation. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `srcaE` in WIDTH: multiplicand or dividend.
- `srcbE` in WIDTH: multiplier or divisor.
- `abortE` in 1: cancels the in-flight op (pipeline flush of the issuing instruction).
- `mthiE`, `mtloE` in 1: write `srcaE` into HI or LO.
- `busy` out 1: state ≠ IDLE (registered).
- `done` out 1: one-cycle pulse after HI/LO update.
- `hi`, `lo` out WIDTH: architectural HI/LO.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - On the edge with `startE` = 1, capture operands.
  - For signed ops, take absolute values and record the result signs.
  - Load the counter with WIDTH, then go to RUN.
  - For DIV/DIVU with `srcbE` = 0, go directly to FIX with the div-by-zero flag set.
- **RUN**
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements each step; on the edge where it reaches 0, go to FIX.
- **FIX**
  - Apply sign correction.
  - Multiply: negate the 2·WIDTH product if operand signs differ.
  - Divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write HI = product[2W-1:W] or remainder; LO = product[W-1:0] or quotient.
  - Go to IDLE.
- Division by zero: HI = dividend (unmodified), LO = all ones. Applies to signed and unsigned.
- Signed overflow DIV MIN/−1: LO = MIN, HI = 0 (falls out of the unsigned core plus sign fix).
- `mthiE`/`mtloE`: honoured only in IDLE with `startE` = 0. Both may write in the same cycle. Ignored otherwise.
- `startE` in RUN or FIX is ignored.
- `abortE` in RUN or FIX: next edge returns to IDLE, HI/LO unchanged, no `done`. `abortE` in IDLE has no effect. `abortE` has priority over FIX completion.

## Timing
- Reset (`reset_n` low, asynchronous): state = IDLE; `hi` = `lo` = 0; `busy` = 0; `done` = 0; counter, accumulator and flags = 0.
- Reset mid-operation discards the op immediately. Operation resumes on the first edge after `reset_n` rises.
- Start on edge E0:
  - `busy` = 1 after E0.
  - RUN occupies edges E1..E_WIDTH.
  - FIX writes HI/LO on edge E_(WIDTH+1).
  - After E_(WIDTH+1): `busy` = 0 and `done` = 1 for exactly one cycle.
- Total latency is WIDTH+1 cycles of `busy` (33 at WIDTH = 32).
- Divide by zero: `busy` for 1 cycle; HI/LO written on E1; `done` after E1.
- A new `startE` is accepted on the same edge at which `done` is high, which gives back-to-back issue.
- `hi`/`lo` are registered; they change only on FIX edges or IDLE mthi/mtlo edges.

## Test plan
- **MULTU**, WIDTH = 32: 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `busy` high exactly 33 cycles; one `done` pulse.
- **MULT** −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- **MULT** 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- **DIV** −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **DIV** 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **DIVU** 100 / 7 → LO = 14, HI = 2.
- **DIVU** 5 / 0 → HI = 5, LO = 0xFFFFFFFF. `busy` for 1 cycle.
- **Abort and ignored start**
  - Preload mthi 0x11 / mtlo 0x22.
  - Start DIVU; assert `abortE` at cycle 10 → idle next edge, HI/LO still 0x11/0x22, no `done`.
  - Repeat with `startE` and `mthiE` pulsed during RUN → both ignored.
- **Reset, mthi/mtlo, back-to-back**
  - Drop `reset_n` at RUN cycle 5 → `busy`, `done`, `hi`, `lo` all 0 without a clock edge.
  - After release, mthi/mtlo write 0xA5A5A5A5 / 0x5A5A5A5A.
  - Issue MULTU 3 × 4 → LO = 12.
  - Issue MULTU 2 × 2 on the `done` cycle → LO = 4, 33 cycles later.
- **Parametrisation**: repeat the MULTU/DIV cases at WIDTH = 8 → latency 9 cycles; 0xFF × 0xFF → HI = 0xFE, LO = 0x01.
